// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter
// Round-robin arbiter and sequencer in front of a shared 3-to-8 active-low
// select decoder. One of eight requesters owns the decoder at a time. Each
// grant is limited to MAX_HOLD cycles, and there is always one idle cycle
// between grants, so two selects are never low together.
//
// Optional feature, macro ARB_LOCK_EN: adds a lock input. While lock is high
// in GRANT, hold expiry is ignored; done and a request drop still end the grant.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   req[7:0]  in   level-sensitive request vector, one bit per requester
//   done      in   the owner releases the grant (looked at only in GRANT)
//   lock      in   (ARB_LOCK_EN only) suppress hold expiry while high
//   sel[2:0]  out  index of the granted requester, to the decoder
//   sel_en_n  out  active-low decoder enable, low only in GRANT
//   gnt_n[0:7]out  active-low one-hot grant, gnt_n[i] low when sel==i and enabled
//   busy      out  high in GRANT and RELEASE
module dec_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
`ifdef ARB_LOCK_EN
   input  logic       lock,
`endif
   output logic [2:0] sel,
   output logic       sel_en_n,
   output logic [0:7] gnt_n,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       winner;
   logic             lock_on;
   logic             hold_hit;
   logic             terminate;

   // First requester at or after p, wrapping mod 8. Scanning from the far end
   // back towards p lets the closest hit overwrite the result last.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      logic [2:0] pick;
      pick = p;
      for (int k = 7; k >= 0; k--) begin
         idx = p + 3'(k);
         if (r[idx]) pick = idx;
      end
      return pick;
   endfunction

   function automatic logic [0:7] onehot_n(input logic [2:0] idx);
      logic [0:7] v;
      v      = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

   always_comb begin
`ifdef ARB_LOCK_EN
      lock_on = lock;
`else
      lock_on = 1'b0;
`endif
      winner = rr_pick(req, ptr);
      // >= rather than == so that a grant held past the limit under lock
      // (cnt saturated above MAX_HOLD) ends as soon as lock drops.
      hold_hit  = (MAX_HOLD != 0) && (cnt >= HOLD_LIM) && !lock_on;
      terminate = done || !req[sel] || hold_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ptr      <= 3'd0;
         cnt      <= '0;
         sel      <= 3'd0;
         sel_en_n <= 1'b1;
         gnt_n    <= '1;
         busy     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_RELEASE: begin
               if (|req) begin
                  sel      <= winner;
                  sel_en_n <= 1'b0;
                  gnt_n    <= onehot_n(winner);
                  cnt      <= CNT_W'(1);
                  busy     <= 1'b1;
                  state    <= S_GRANT;
               end else if (state == S_RELEASE) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_GRANT: begin
               if (terminate) begin
                  // sel is left as is; the decoder is already disabled.
                  sel_en_n <= 1'b1;
                  gnt_n    <= '1;
                  ptr      <= sel + 3'd1;
                  state    <= S_RELEASE;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               sel_en_n <= 1'b1;
               gnt_n    <= '1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
